pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Fetch-redirect and stall controller for the program counter. It arbitrates the four sources that can redirect or freeze fetch: debug halt, trap entry, taken branch/jump from EX, and pipeline stall. It drives the `pc` block's `jump`, `jump_addr` and `hold` inputs, plus a `flush` to the IF/ID pipeline registers. All outputs are registered, so each request reaches the PC one cycle after it is sampled.

## Interface

Parameters:
- `ADDR_W`, 32: instruction address width; matches `INST_ADDR_WIDTH`.
- `RST_ADDR`, 32'h0000_0000: reset value of `jump_addr`; matches `INI_INST_ADDR`.
- `FLUSH_CYC`, 2: number of flush cycles per redirect. Legal range 1..7.
- `STALL_MAX`, 255: consecutive stall-hold cycles before the timeout flag is set. Legal range 1..255.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `br_req` in 1: branch/jump taken in EX. Single-cycle pulse.
- `br_addr` in ADDR_W: branch target, valid while `br_req`=1.
- `trap_req` in 1: trap/interrupt entry request. Level; held until `trap_ack`.
- `trap_addr` in ADDR_W: trap vector, valid while `trap_req`=1.
- `stall_req` in 1: pipeline stall request (load-use, bus wait). Level.
- `halt_req` in 1: debug halt request. Level.
- `jump` out 1: to `pc.jump`.
- `jump_addr` out ADDR_W: to `pc.jump_addr`.
- `hold` out 1: to `pc.hold`.
- `flush` out 1: invalidate IF/ID contents.
- `trap_ack` out 1: one-cycle acknowledge of a taken trap.
- `halted` out 1: core is in debug halt.
- `stall_timeout` out 1: sticky flag. Cleared only by reset.

## Operation

States: RUN, FLUSH, HALT. Flush counter `fcnt` is 3 bits; stall counter `scnt` is 8 bits.

RUN evaluates requests at each edge with priority halt > trap > branch > stall:
- `halt_req`=1: go to HALT. Next cycle `hold`=1, `halted`=1.
- `trap_req`=1: set `jump`=1, `jump_addr`=`trap_addr`, `trap_ack`=1, `flush`=1. Go to FLUSH with `fcnt`=FLUSH_CYC-1.
- `br_req`=1: same as trap, but `jump_addr`=`br_addr` and `trap_ack` stays 0.
- `stall_req`=1: set `hold`=1 next cycle and stay in RUN.
- No request: `jump`, `hold`, `flush`, `trap_ack` all 0.

A `br_req` that loses to trap or halt is dropped, not queued.

FLUSH:
- `jump` and `trap_ack` return to 0 after their single cycle. `hold` stays 0.
- If `fcnt`=0: next state RUN, `flush`<=0. Otherwise decrement `fcnt` and keep `flush`=1.
- `flush` is therefore high for exactly FLUSH_CYC cycles, and the first of those is the `jump` cycle.
- `br_req` and `stall_req` are ignored for the whole FLUSH period, including the last cycle.
- `trap_req` and `halt_req` are levels, so they are taken at the first RUN evaluation.

HALT:
- `hold`=1, `halted`=1, `flush`=0, `jump`=0.
- When `halt_req`=0 at an edge: go to RUN, and `hold` and `halted` drop next cycle.
- A pending trap is then taken at the following edge.

Invariants:
- `jump` and `hold` are never 1 in the same cycle.
- `jump_addr` holds its last value while `jump`=0.

Stall watchdog:
- `scnt` clears on any edge where `hold` is not set by a stall.
- Otherwise `scnt` increments, saturating at 255.
- The edge at which the increment makes `scnt`=STALL_MAX also sets `stall_timeout`=1.
- HALT holds do not count toward the watchdog.

## Timing

- Request-to-PC latency is 1 cycle: a request sampled at edge N produces `jump`/`hold` during cycle N+1, and the PC acts at edge N+1.
- Reset, asynchronous, takes effect immediately:
  - state RUN, `fcnt`=0, `scnt`=0;
  - `jump`, `hold`, `flush`, `trap_ack`, `halted`, `stall_timeout` = 0;
  - `jump_addr`=RST_ADDR.
- Reset asserted mid-FLUSH or mid-HALT abandons the operation. No pending request is remembered.
- Back-to-back redirects: the minimum spacing between two `jump` pulses is FLUSH_CYC+1 cycles.

## Test plan

1. Reset: assert `rst`=0 in the middle of FLUSH. All outputs must go to 0 with no clock edge, and `jump_addr` to 32'h0. After release with no requests, outputs must stay 0.
2. Branch: `br_req` pulse with `br_addr`=32'h0001_4294 at edge N, FLUSH_CYC=2.
   - Expect `jump`=1 only in cycle N+1, `jump_addr`=32'h0001_4294.
   - Expect `flush`=1 in cycles N+1..N+2.
   - A second `br_req` at edge N+1 must produce no jump.
3. Collision: `trap_req` with `trap_addr`=32'h0000_0100 and `br_req` at the same edge.
   - Expect `jump_addr`=32'h100 and `trap_ack`=1 for one cycle.
   - The branch must never be issued.
4. Stall and watchdog: STALL_MAX=4, `stall_req` high at edges N..N+4.
   - Expect `hold`=1 in cycles N+1..N+5 and `stall_timeout`=1 from cycle N+4 onward, still 1 after the stall ends.
   - Separately, `stall_req` high during FLUSH must give `hold`=0.
5. Halt with pending trap: `halt_req` and `trap_req` high together.
   - Expect HALT with `hold`=`halted`=1 and no `trap_ack`.
   - Drop `halt_req` at edge M: `halted`=0 in cycle M+1, then `jump`=1 with the trap vector and `trap_ack`=1 in cycle M+2.
6. Mutual exclusion: random `br_req`/`trap_req`/`stall_req`/`halt_req` for 10k cycles. Assert `jump` and `hold` are never both 1, and that every `trap_ack` coincides with `jump`=1.

Source files
------------

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-redirect and stall controller for the program counter.
// Arbitrates debug halt, trap entry, taken branch and pipeline stall, and
// drives registered jump/jump_addr/hold to the pc block plus an IF/ID flush.
module pc_ctrl #(
   parameter int unsigned          ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]    RST_ADDR  = '0,
   parameter int unsigned          FLUSH_CYC = 2,
   parameter int unsigned          STALL_MAX = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              br_req,
   input  logic [ADDR_W-1:0] br_addr,
   input  logic              trap_req,
   input  logic [ADDR_W-1:0] trap_addr,
   input  logic              stall_req,
   input  logic              halt_req,
   output logic              jump,
   output logic [ADDR_W-1:0] jump_addr,
   output logic              hold,
   output logic              flush,
   output logic              trap_ack,
   output logic              halted,
   output logic              stall_timeout
);

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      HALT
   } state_t;

   localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYC - 1);
   localparam logic [7:0] SCNT_MAX  = 8'(STALL_MAX);
   localparam logic [7:0] SCNT_SAT  = 8'hFF;

   state_t            state, state_nxt;
   logic [2:0]        fcnt, fcnt_nxt;
   logic [7:0]        scnt, scnt_nxt, scnt_inc;
   logic              jump_nxt, hold_nxt, flush_nxt, trap_ack_nxt, halted_nxt;
   logic              stall_timeout_nxt;
   logic [ADDR_W-1:0] jump_addr_nxt;
   logic              stall_hold;

   // State, counters and all outputs are registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= RUN;
         fcnt          <= '0;
         scnt          <= '0;
         jump          <= 1'b0;
         jump_addr     <= RST_ADDR;
         hold          <= 1'b0;
         flush         <= 1'b0;
         trap_ack      <= 1'b0;
         halted        <= 1'b0;
         stall_timeout <= 1'b0;
      end else begin
         state         <= state_nxt;
         fcnt          <= fcnt_nxt;
         scnt          <= scnt_nxt;
         jump          <= jump_nxt;
         jump_addr     <= jump_addr_nxt;
         hold          <= hold_nxt;
         flush         <= flush_nxt;
         trap_ack      <= trap_ack_nxt;
         halted        <= halted_nxt;
         stall_timeout <= stall_timeout_nxt;
      end
   end

   // Request arbitration (halt > trap > branch > stall) and next outputs.
   always_comb begin
      state_nxt     = state;
      fcnt_nxt      = fcnt;
      jump_nxt      = 1'b0;
      jump_addr_nxt = jump_addr;
      hold_nxt      = 1'b0;
      flush_nxt     = 1'b0;
      trap_ack_nxt  = 1'b0;
      halted_nxt    = 1'b0;
      stall_hold    = 1'b0;

      unique case (state)
         RUN: begin
            if (halt_req) begin
               state_nxt  = HALT;
               hold_nxt   = 1'b1;
               halted_nxt = 1'b1;
            end else if (trap_req) begin
               state_nxt     = FLUSH;
               fcnt_nxt      = FCNT_INIT;
               jump_nxt      = 1'b1;
               jump_addr_nxt = trap_addr;
               trap_ack_nxt  = 1'b1;
               flush_nxt     = 1'b1;
            end else if (br_req) begin
               state_nxt     = FLUSH;
               fcnt_nxt      = FCNT_INIT;
               jump_nxt      = 1'b1;
               jump_addr_nxt = br_addr;
               flush_nxt     = 1'b1;
            end else if (stall_req) begin
               hold_nxt   = 1'b1;
               stall_hold = 1'b1;
            end
         end
         FLUSH: begin
            // Every request is ignored here, including on the final cycle;
            // trap and halt are levels and get picked up once back in RUN.
            if (fcnt == '0) begin
               state_nxt = RUN;
            end else begin
               fcnt_nxt  = fcnt - 3'd1;
               flush_nxt = 1'b1;
            end
         end
         HALT: begin
            if (halt_req) begin
               hold_nxt   = 1'b1;
               halted_nxt = 1'b1;
            end else begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // Stall watchdog: counts consecutive stall-driven holds, sticky timeout.
   always_comb begin
      scnt_inc          = (scnt == SCNT_SAT) ? scnt : scnt + 8'd1;
      scnt_nxt          = '0;
      stall_timeout_nxt = stall_timeout;
      if (stall_hold) begin
         scnt_nxt = scnt_inc;
         if ((scnt != SCNT_SAT) && (scnt_inc == SCNT_MAX)) begin
            stall_timeout_nxt = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table plus randomized
// traffic checked against a timestamp-based reference model.
module tb_pc_ctrl;

   localparam int FC   = 2;
   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        br_req = 1'b0, trap_req = 1'b0, stall_req = 1'b0, halt_req = 1'b0;
   logic [31:0] br_addr = '0, trap_addr = '0;
   logic        jump, hold, flush, trap_ack, halted, stall_timeout;
   logic [31:0] jump_addr;

   int checks = 0;
   int errors = 0;

   pc_ctrl #(
      .ADDR_W   (32),
      .RST_ADDR (32'h0000_0000),
      .FLUSH_CYC(FC),
      .STALL_MAX(SMAX)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .br_req       (br_req),
      .br_addr      (br_addr),
      .trap_req     (trap_req),
      .trap_addr    (trap_addr),
      .stall_req    (stall_req),
      .halt_req     (halt_req),
      .jump         (jump),
      .jump_addr    (jump_addr),
      .hold         (hold),
      .flush        (flush),
      .trap_ack     (trap_ack),
      .halted       (halted),
      .stall_timeout(stall_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout simulation time limit exceeded");
      $fatal(1, "time limit");
   end

   // flags order: {jump, hold, flush, trap_ack, halted, stall_timeout}
   typedef struct {
      logic        br;
      logic [31:0] ba;
      logic        tr;
      logic [31:0] ta;
      logic        st;
      logic        hl;
      logic [5:0]  ef;
      logic [31:0] ea;
   } vec_t;

   // Reference model: redirects tracked by edge timestamps.
   int          e, r, srun;
   bit          in_halt, tmo;
   logic [31:0] maddr;
   logic [5:0]  mexp;

   task automatic model_reset();
      e = 0; r = -100; srun = 0; in_halt = 0; tmo = 0; maddr = '0; mexp = '0;
   endtask

   task automatic model_edge();
      bit j, h, f, a, hd, sh;
      j = 0; h = 0; f = 0; a = 0; hd = 0; sh = 0;
      e++;
      if (in_halt) begin
         if (halt_req) begin h = 1; hd = 1; end
         else in_halt = 0;
      end else if (e > r && e <= r + FC) begin
         f = (e < r + FC);
      end else if (halt_req) begin
         in_halt = 1; h = 1; hd = 1;
      end else if (trap_req) begin
         r = e; j = 1; a = 1; f = 1; maddr = trap_addr;
      end else if (br_req) begin
         r = e; j = 1; f = 1; maddr = br_addr;
      end else if (stall_req) begin
         h = 1; sh = 1;
      end
      srun = sh ? ((srun < 255) ? srun + 1 : 255) : 0;
      if (srun >= SMAX) tmo = 1;
      mexp = {j, h, f, a, hd, tmo};
   endtask

   // Drive inputs (called at negedge), clock one edge, return at next negedge.
   task automatic drive(input logic b, input logic [31:0] ba, input logic t,
                        input logic [31:0] ta, input logic s, input logic h);
      br_req = b; br_addr = ba; trap_req = t; trap_addr = ta;
      stall_req = s; halt_req = h;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [5:0] ef, input logic [31:0] ea);
      logic [5:0] got;
      got = {jump, hold, flush, trap_ack, halted, stall_timeout};
      checks++;
      if (got !== ef) begin
         errors++;
         $display("FAIL %s flags got %b want %b (j h f ack hlt tmo) t=%0t", nm, got, ef, $time);
      end
      checks++;
      if (jump_addr !== ea) begin
         errors++;
         $display("FAIL %s jump_addr got %h want %h t=%0t", nm, jump_addr, ea, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      br_req = 0; trap_req = 0; stall_req = 0; halt_req = 0;
      #2;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   vec_t tbl[25];

   initial begin
      tbl[0]  = '{0, 32'h0,        0, 32'h0,   0, 0, 6'b000000, 32'h0};
      tbl[1]  = '{1, 32'h0001_4294, 0, 32'h0,  0, 0, 6'b101000, 32'h0001_4294};
      tbl[2]  = '{1, 32'hDEAD_0000, 0, 32'h0,  0, 0, 6'b001000, 32'h0001_4294};
      tbl[3]  = '{0, 32'h0,        0, 32'h0,   0, 0, 6'b000000, 32'h0001_4294};
      tbl[4]  = '{1, 32'hBEEF_0000, 1, 32'h100, 0, 0, 6'b101100, 32'h100};
      tbl[5]  = '{0, 32'h0,        0, 32'h0,   0, 0, 6'b001000, 32'h100};
      tbl[6]  = '{0, 32'h0,        0, 32'h0,   1, 0, 6'b000000, 32'h100};
      tbl[7]  = '{0, 32'h0,        0, 32'h0,   0, 0, 6'b000000, 32'h100};
      tbl[8]  = '{0, 32'h0,        1, 32'h200, 0, 1, 6'b010010, 32'h100};
      tbl[9]  = '{0, 32'h0,        1, 32'h200, 0, 1, 6'b010010, 32'h100};
      tbl[10] = '{0, 32'h0,        1, 32'h200, 0, 0, 6'b000000, 32'h100};
      tbl[11] = '{0, 32'h0,        1, 32'h200, 0, 0, 6'b101100, 32'h200};
      tbl[12] = '{0, 32'h0,        0, 32'h0,   0, 0, 6'b001000, 32'h200};
      tbl[13] = '{0, 32'h0,        0, 32'h0,   0, 0, 6'b000000, 32'h200};
      tbl[14] = '{0, 32'h0,        0, 32'h0,   1, 0, 6'b010000, 32'h200};
      tbl[15] = '{0, 32'h0,        0, 32'h0,   1, 0, 6'b010000, 32'h200};
      tbl[16] = '{0, 32'h0,        0, 32'h0,   1, 0, 6'b010000, 32'h200};
      tbl[17] = '{0, 32'h0,        0, 32'h0,   1, 0, 6'b010001, 32'h200};
      tbl[18] = '{0, 32'h0,        0, 32'h0,   1, 0, 6'b010001, 32'h200};
      tbl[19] = '{0, 32'h0,        0, 32'h0,   0, 0, 6'b000001, 32'h200};
      tbl[20] = '{1, 32'h300,      0, 32'h0,   1, 0, 6'b101001, 32'h300};
      tbl[21] = '{0, 32'h0,        0, 32'h0,   1, 0, 6'b001001, 32'h300};
      tbl[22] = '{0, 32'h0,        0, 32'h0,   1, 0, 6'b000001, 32'h300};
      tbl[23] = '{0, 32'h0,        0, 32'h0,   1, 1, 6'b010011, 32'h300};
      tbl[24] = '{0, 32'h0,        0, 32'h0,   0, 0, 6'b000001, 32'h300};

      // Reset while a redirect is being flushed.
      do_reset();
      chk("reset_idle", 6'b000000, 32'h0);
      drive(1, 32'hCAFE_0004, 0, 32'h0, 0, 0);
      chk("pre_reset_jump", 6'b101000, 32'hCAFE_0004);
      br_req = 0;
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset", 6'b000000, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         drive(0, 32'h0, 0, 32'h0, 0, 0);
         chk("post_reset_idle", 6'b000000, 32'h0);
      end

      // Directed vector table.
      do_reset();
      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].br, tbl[i].ba, tbl[i].tr, tbl[i].ta, tbl[i].st, tbl[i].hl);
         chk($sformatf("vec%0d", i), tbl[i].ef, tbl[i].ea);
      end

      // Randomized traffic against the reference model.
      do_reset();
      begin
         logic h;
         h = 1'b0;
         for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(19) == 0) h = ~h;
            drive(($urandom_range(4) == 0), $urandom(),
                  ($urandom_range(7) == 0), $urandom(),
                  ($urandom_range(2) == 0), h);
            chk("rand", mexp, maddr);
            checks++;
            if (jump && hold) begin
               errors++;
               $display("FAIL excl jump=%b hold=%b want not both t=%0t", jump, hold, $time);
            end
            checks++;
            if (trap_ack && !jump) begin
               errors++;
               $display("FAIL ack_jump trap_ack=%b jump=%b want jump=1 t=%0t", trap_ack, jump, $time);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
